// File: rtl/kmeans_pkg.sv
// +------------------------------------------------------------------+
// | kmeans_pkg                                                       |
// | Shared types and sizing helpers for the K-means centroid stage.  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

package kmeans_pkg;

   typedef enum logic [1:0] {
      ACC = 2'd0,
      DIV = 2'd1,
      OUT = 2'd2
   } kmeans_state_e;

   localparam int c_DEF_K  = 4;
   localparam int c_DEF_DW = 32;
   localparam int c_DEF_CW = 16;

   // A sum of at most 2^CW-1 values below 2^DW always fits in DW+CW bits.
   function automatic int kmeans_sw(input int dw, input int cw);
      return dw + cw;
   endfunction

endpackage

`default_nettype wire

// File: rtl/kmeans_udiv.sv
// +------------------------------------------------------------------+
// | kmeans_udiv                                                      |
// | Unsigned restoring divider, one quotient bit per clock.          |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module kmeans_udiv #(
   parameter int SW = 48,
   parameter int CW = 16,
   parameter int DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_start,
   input  logic [SW-1:0] i_dividend,
   input  logic [CW-1:0] i_divisor,
   output logic          o_busy,
   output logic          o_done,
   output logic [DW-1:0] o_quotient
);

   localparam int STW = $clog2(SW);

   logic [SW-1:0]  r_quo;
   logic [CW-1:0]  r_rem;
   logic [CW-1:0]  r_div;
   logic [STW-1:0] r_step;
   logic           r_busy;

   logic [CW:0]    w_trial;
   logic           w_ge;
   logic [CW-1:0]  w_rem_next;
   logic [SW-1:0]  w_quo_next;

   // Dividend bits shift out of the top of r_quo while quotient bits shift in.
   assign w_trial    = {r_rem, r_quo[SW-1]};
   assign w_ge       = (w_trial >= {1'b0, r_div});
   assign w_rem_next = w_ge ? CW'(w_trial - {1'b0, r_div}) : w_trial[CW-1:0];
   assign w_quo_next = {r_quo[SW-2:0], w_ge};

   // Done is flagged during the final iteration so the caller can latch the
   // finished quotient on the same edge.
   assign o_busy     = r_busy;
   assign o_done     = r_busy && (r_step == STW'(SW - 1));
   assign o_quotient = w_quo_next[DW-1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         r_quo  <= '0;
         r_rem  <= '0;
         r_div  <= '0;
         r_step <= '0;
         r_busy <= 1'b0;
      end else if (i_start) begin
         r_quo  <= i_dividend;
         r_rem  <= '0;
         r_div  <= i_divisor;
         r_step <= '0;
         r_busy <= 1'b1;
      end else if (r_busy) begin
         r_quo  <= w_quo_next;
         r_rem  <= w_rem_next;
         r_step <= r_step + STW'(1);
         if (o_done) begin
            r_busy <= 1'b0;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/kmeans_centroid_acc.sv
// +------------------------------------------------------------------+
// | kmeans_centroid_acc                                              |
// | Per-cluster sum/count accumulation and centroid division stage.  |
// | Optional: KMEANS_ROUND_EN selects round-half-up division.        |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module kmeans_centroid_acc
   import kmeans_pkg::*;
#(
   parameter  int K  = c_DEF_K,
   parameter  int DW = c_DEF_DW,
   parameter  int CW = c_DEF_CW,
   localparam int SW = kmeans_sw(DW, CW),
   localparam int IW = $clog2(K)
) (
   input  logic          acc_clk,
   input  logic          acc_rst,
   input  logic          clr,
   input  logic          pt_valid,
   output logic          pt_ready,
   input  logic [DW-1:0] pt_x,
   input  logic [DW-1:0] pt_y,
   input  logic [IW-1:0] pt_cls,
   input  logic          done_in,
   output logic          cen_valid,
   input  logic          cen_ready,
   output logic [IW-1:0] cen_idx,
   output logic [DW-1:0] cen_x,
   output logic [DW-1:0] cen_y,
   output logic          cen_empty,
   output logic          busy,
   output logic          ovf
);

   kmeans_state_e r_state, w_state_next;

   logic [SW-1:0] r_sum_x [K];
   logic [SW-1:0] r_sum_y [K];
   logic [CW-1:0] r_cnt   [K];
   logic [IW-1:0] r_idx;
   logic [DW-1:0] r_cen_x, r_cen_y;
   logic          r_cen_empty;
   logic          r_ovf;

   logic          w_pt_acc, w_last, w_cnt_zero;
   logic [CW-1:0] w_cnt_cur;
   logic [SW-1:0] w_dvd_x, w_dvd_y;
   logic          w_div_start, w_div_rst, w_div_done;
   logic          w_bx, w_by, w_dx_done, w_dy_done;
   logic [DW-1:0] w_qx, w_qy;

   assign pt_ready  = (r_state == ACC);
   assign cen_valid = (r_state == OUT);
   assign busy      = (r_state != ACC);
   assign cen_idx   = r_idx;
   assign cen_x     = r_cen_x;
   assign cen_y     = r_cen_y;
   assign cen_empty = r_cen_empty;
   assign ovf       = r_ovf;

   assign w_pt_acc    = pt_valid && pt_ready;
   assign w_last      = (r_idx == IW'(K - 1));
   assign w_cnt_cur   = r_cnt[r_idx];
   assign w_cnt_zero  = (w_cnt_cur == '0);
   assign w_div_start = (r_state == DIV) && !w_cnt_zero && !w_bx && !w_by;
   assign w_div_rst   = acc_rst || clr;
   assign w_div_done  = w_dx_done && w_dy_done;

`ifdef KMEANS_ROUND_EN
   // Adding half the count before the floor gives round-half-up.
   assign w_dvd_x = r_sum_x[r_idx] + SW'(w_cnt_cur >> 1);
   assign w_dvd_y = r_sum_y[r_idx] + SW'(w_cnt_cur >> 1);
`else
   assign w_dvd_x = r_sum_x[r_idx];
   assign w_dvd_y = r_sum_y[r_idx];
`endif

   kmeans_udiv #(.SW(SW), .CW(CW), .DW(DW)) u_div_x (
      .clk        (acc_clk),
      .rst        (w_div_rst),
      .i_start    (w_div_start),
      .i_dividend (w_dvd_x),
      .i_divisor  (w_cnt_cur),
      .o_busy     (w_bx),
      .o_done     (w_dx_done),
      .o_quotient (w_qx)
   );

   kmeans_udiv #(.SW(SW), .CW(CW), .DW(DW)) u_div_y (
      .clk        (acc_clk),
      .rst        (w_div_rst),
      .i_start    (w_div_start),
      .i_dividend (w_dvd_y),
      .i_divisor  (w_cnt_cur),
      .o_busy     (w_by),
      .o_done     (w_dy_done),
      .o_quotient (w_qy)
   );

   always_ff @(posedge acc_clk) begin
      if (acc_rst) begin
         r_state <= ACC;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ACC:     if (done_in) w_state_next = DIV;
         DIV:     if (w_cnt_zero || w_div_done) w_state_next = OUT;
         OUT:     if (cen_ready) w_state_next = w_last ? ACC : DIV;
         default: w_state_next = ACC;
      endcase
      if (clr) begin
         w_state_next = ACC;
      end
   end

   always_ff @(posedge acc_clk) begin
      if (acc_rst || clr) begin
         for (int i = 0; i < K; i++) begin
            r_sum_x[i] <= '0;
            r_sum_y[i] <= '0;
            r_cnt[i]   <= '0;
         end
         r_ovf       <= 1'b0;
         r_idx       <= '0;
         r_cen_x     <= '0;
         r_cen_y     <= '0;
         r_cen_empty <= 1'b0;
      end else begin
         case (r_state)
            ACC: begin
               if (w_pt_acc) begin
                  if (r_cnt[pt_cls] == '1) begin
                     r_ovf <= 1'b1;
                  end else begin
                     r_sum_x[pt_cls] <= r_sum_x[pt_cls] + SW'(pt_x);
                     r_sum_y[pt_cls] <= r_sum_y[pt_cls] + SW'(pt_y);
                     r_cnt[pt_cls]   <= r_cnt[pt_cls] + CW'(1);
                  end
               end
               if (done_in) begin
                  r_idx <= '0;
               end
            end
            DIV: begin
               if (w_cnt_zero) begin
                  r_cen_x     <= '0;
                  r_cen_y     <= '0;
                  r_cen_empty <= 1'b1;
               end else if (w_div_done) begin
                  r_cen_x     <= w_qx;
                  r_cen_y     <= w_qy;
                  r_cen_empty <= 1'b0;
               end
            end
            OUT: begin
               if (cen_ready) begin
                  if (w_last) begin
                     for (int i = 0; i < K; i++) begin
                        r_sum_x[i] <= '0;
                        r_sum_y[i] <= '0;
                        r_cnt[i]   <= '0;
                     end
                  end else begin
                     r_idx <= r_idx + IW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_kmeans_centroid_acc.sv
// +------------------------------------------------------------------+
// | tb_kmeans_centroid_acc                                           |
// | Directed bench for kmeans_centroid_acc (CW=16 and CW=2 builds).  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
`default_nettype none

module tb_kmeans_centroid_acc;

   typedef struct {
      int          n;
      logic [1:0]  cls [4];
      logic [31:0] x   [4];
      logic [31:0] y   [4];
      logic [31:0] ex  [4];
      logic [31:0] ey  [4];
      logic [3:0]  emp;
   } vec_t;

`ifdef KMEANS_ROUND_EN
   localparam logic [31:0] c_V1_X  = 32'd2;
   localparam logic [31:0] c_V3_X3 = 32'd6;
   localparam logic [31:0] c_V3_Y3 = 32'd10;
`else
   localparam logic [31:0] c_V1_X  = 32'd1;
   localparam logic [31:0] c_V3_X3 = 32'd5;
   localparam logic [31:0] c_V3_Y3 = 32'd9;
`endif

   logic        clk = 1'b0;
   logic        rst, clr, pt_valid, done_in, cen_ready, sel;
   logic [1:0]  pt_cls;
   logic [31:0] pt_x, pt_y;

   logic        a_pt_ready, a_valid, a_empty, a_busy, a_ovf;
   logic [1:0]  a_idx;
   logic [31:0] a_x, a_y;
   logic        b_pt_ready, b_valid, b_empty, b_busy, b_ovf;
   logic [1:0]  b_idx;
   logic [31:0] b_x, b_y;

   logic        m_pt_ready, m_valid, m_empty, m_busy, m_ovf;
   logic [1:0]  m_idx;
   logic [31:0] m_x, m_y;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   kmeans_centroid_acc #(.K(4), .DW(32), .CW(16)) u_dut_a (
      .acc_clk (clk),               .acc_rst   (rst),
      .clr     (clr),               .pt_valid  (pt_valid && !sel),
      .pt_ready(a_pt_ready),        .pt_x      (pt_x),
      .pt_y    (pt_y),              .pt_cls    (pt_cls),
      .done_in (done_in && !sel),   .cen_valid (a_valid),
      .cen_ready(cen_ready && !sel), .cen_idx  (a_idx),
      .cen_x   (a_x),               .cen_y     (a_y),
      .cen_empty(a_empty),          .busy      (a_busy),
      .ovf     (a_ovf)
   );

   kmeans_centroid_acc #(.K(4), .DW(32), .CW(2)) u_dut_b (
      .acc_clk (clk),               .acc_rst   (rst),
      .clr     (clr),               .pt_valid  (pt_valid && sel),
      .pt_ready(b_pt_ready),        .pt_x      (pt_x),
      .pt_y    (pt_y),              .pt_cls    (pt_cls),
      .done_in (done_in && sel),    .cen_valid (b_valid),
      .cen_ready(cen_ready && sel), .cen_idx   (b_idx),
      .cen_x   (b_x),               .cen_y     (b_y),
      .cen_empty(b_empty),          .busy      (b_busy),
      .ovf     (b_ovf)
   );

   assign m_pt_ready = sel ? b_pt_ready : a_pt_ready;
   assign m_valid    = sel ? b_valid    : a_valid;
   assign m_empty    = sel ? b_empty    : a_empty;
   assign m_busy     = sel ? b_busy     : a_busy;
   assign m_ovf      = sel ? b_ovf      : a_ovf;
   assign m_idx      = sel ? b_idx      : a_idx;
   assign m_x        = sel ? b_x        : a_x;
   assign m_y        = sel ? b_y        : a_y;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send_point(input logic [1:0] c, input logic [31:0] x, input logic [31:0] y);
      pt_valid = 1'b1;
      pt_cls   = c;
      pt_x     = x;
      pt_y     = y;
      tick;
      pt_valid = 1'b0;
   endtask

   task automatic pulse_done;
      done_in = 1'b1;
      tick;
      done_in = 1'b0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!m_valid && n < 300) begin
         tick;
         n++;
      end
      if (!m_valid) check("valid_timeout", 64'(0), 64'(1));
   endtask

   task automatic drain(input vec_t v, input string tag);
      int n;
      for (int i = 0; i < 4; i++) begin
         wait_valid(n);
         check({tag, "_idx"},   64'(m_idx),   64'(i));
         check({tag, "_x"},     64'(m_x),     64'(v.ex[i]));
         check({tag, "_y"},     64'(m_y),     64'(v.ey[i]));
         check({tag, "_empty"}, 64'(m_empty), 64'(v.emp[i]));
         cen_ready = 1'b1;
         tick;
         cen_ready = 1'b0;
      end
      check({tag, "_pt_ready"}, 64'(m_pt_ready), 64'(1));
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      for (int i = 0; i < v.n; i++) send_point(v.cls[i], v.x[i], v.y[i]);
      pulse_done;
      drain(v, tag);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [4];
      vec_t v;
      int   n;
      logic seen;

      vecs[0] = '{3, '{2'd0, 2'd0, 2'd0, 2'd0},
                  '{32'd10, 32'd20, 32'd30, 32'd0}, '{32'd20, 32'd40, 32'd60, 32'd0},
                  '{32'd20, 32'd0, 32'd0, 32'd0},   '{32'd40, 32'd0, 32'd0, 32'd0}, 4'b1110};
      vecs[1] = '{2, '{2'd1, 2'd1, 2'd0, 2'd0},
                  '{32'd1, 32'd2, 32'd0, 32'd0},    '{32'd1, 32'd2, 32'd0, 32'd0},
                  '{32'd0, c_V1_X, 32'd0, 32'd0},   '{32'd0, c_V1_X, 32'd0, 32'd0}, 4'b1101};
      vecs[2] = '{3, '{2'd2, 2'd2, 2'd2, 2'd0},
                  '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0},
                  '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0},
                  '{32'd0, 32'd0, 32'hFFFFFFFF, 32'd0}, '{32'd0, 32'd0, 32'hFFFFFFFF, 32'd0}, 4'b1011};
      vecs[3] = '{4, '{2'd0, 2'd1, 2'd3, 2'd3},
                  '{32'd7, 32'd100, 32'd5, 32'd6},  '{32'd3, 32'd0, 32'd9, 32'd10},
                  '{32'd7, 32'd100, 32'd0, c_V3_X3}, '{32'd3, 32'd0, 32'd0, c_V3_Y3}, 4'b0100};

      rst = 1'b1; clr = 1'b0; pt_valid = 1'b0; done_in = 1'b0; cen_ready = 1'b0;
      sel = 1'b0; pt_cls = 2'd0; pt_x = 32'd0; pt_y = 32'd0;
      repeat (3) tick;
      rst = 1'b0;

      check("rst_pt_ready",  64'(m_pt_ready), 64'(1));
      check("rst_cen_valid", 64'(m_valid),    64'(0));
      check("rst_busy",      64'(m_busy),     64'(0));
      check("rst_ovf",       64'(m_ovf),      64'(0));
      check("rst_idx",       64'(m_idx),      64'(0));
      check("rst_x",         64'(m_x),        64'(0));
      check("rst_y",         64'(m_y),        64'(0));
      check("rst_empty",     64'(m_empty),    64'(0));

      for (int t = 0; t < 4; t++) run_vec(vecs[t], $sformatf("vec%0d", t));

      // Latency from DIV entry to first centroid (cluster 0 nonempty).
      send_point(2'd0, 32'd4, 32'd4);
      pulse_done;
      check("lat_busy", 64'(m_busy), 64'(1));
      wait_valid(n);
      check("lat_cycles", 64'(n), 64'(49));
      v = '{1, '{2'd0, 2'd0, 2'd0, 2'd0}, '{32'd4, 32'd0, 32'd0, 32'd0}, '{32'd4, 32'd0, 32'd0, 32'd0},
            '{32'd4, 32'd0, 32'd0, 32'd0}, '{32'd4, 32'd0, 32'd0, 32'd0}, 4'b1110};
      drain(v, "lat");

      // Backpressure on idx0.
      send_point(2'd0, 32'd8, 32'd16);
      send_point(2'd1, 32'd3, 32'd3);
      pulse_done;
      wait_valid(n);
      for (int k = 0; k < 5; k++) begin
         tick;
         check("bp_valid", 64'(m_valid), 64'(1));
         check("bp_idx",   64'(m_idx),   64'(0));
         check("bp_x",     64'(m_x),     64'(8));
         check("bp_y",     64'(m_y),     64'(16));
      end
      cen_ready = 1'b1; tick; cen_ready = 1'b0;
      check("bp_valid_drop", 64'(m_valid), 64'(0));
      wait_valid(n);
      check("bp_next_idx", 64'(m_idx), 64'(1));
      check("bp_next_x",   64'(m_x),   64'(3));
      for (int i = 0; i < 3; i++) begin
         wait_valid(n);
         cen_ready = 1'b1; tick; cen_ready = 1'b0;
      end
      check("bp_end_ready", 64'(m_pt_ready), 64'(1));

      // clr in the middle of a divide.
      send_point(2'd0, 32'd100, 32'd100);
      pulse_done;
      repeat (10) tick;
      clr = 1'b1; tick; clr = 1'b0;
      check("clr_pt_ready", 64'(m_pt_ready), 64'(1));
      check("clr_busy",     64'(m_busy),     64'(0));
      seen = 1'b0;
      for (int k = 0; k < 60; k++) begin
         if (m_valid) seen = 1'b1;
         tick;
      end
      check("clr_no_valid", 64'(seen), 64'(0));

      // clr beats a simultaneous point and done_in.
      pt_valid = 1'b1; pt_cls = 2'd0; pt_x = 32'd1000; pt_y = 32'd1000;
      done_in = 1'b1; clr = 1'b1;
      tick;
      pt_valid = 1'b0; done_in = 1'b0; clr = 1'b0;
      check("clr_done_busy", 64'(m_busy), 64'(0));
      v = '{1, '{2'd0, 2'd0, 2'd0, 2'd0}, '{32'd5, 32'd0, 32'd0, 32'd0}, '{32'd5, 32'd0, 32'd0, 32'd0},
            '{32'd5, 32'd0, 32'd0, 32'd0}, '{32'd5, 32'd0, 32'd0, 32'd0}, 4'b1110};
      run_vec(v, "clr_after");

      // Count saturation on the CW=2 instance.
      sel = 1'b1;
      send_point(2'd3, 32'd4, 32'd1);
      send_point(2'd3, 32'd4, 32'd1);
      send_point(2'd3, 32'd4, 32'd1);
      check("sat_ovf_before", 64'(m_ovf), 64'(0));
      send_point(2'd3, 32'd100, 32'd1);
      check("sat_ovf_set", 64'(m_ovf), 64'(1));
      pulse_done;
      v = '{0, '{2'd0, 2'd0, 2'd0, 2'd0}, '{32'd0, 32'd0, 32'd0, 32'd0}, '{32'd0, 32'd0, 32'd0, 32'd0},
            '{32'd0, 32'd0, 32'd0, 32'd4}, '{32'd0, 32'd0, 32'd0, 32'd1}, 4'b0111};
      drain(v, "sat");
      check("sat_ovf_sticky", 64'(m_ovf), 64'(1));
      clr = 1'b1; tick; clr = 1'b0;
      check("sat_ovf_clr", 64'(m_ovf), 64'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
